// File: rtl/l2_cache_control_if.sv
// Signal bundle between the L2 controller, upstream L1/arbiter, physical memory and the datapath.
// The master modport is the controller's view; the slave modport is the surrounding system's view.
interface l2_cache_control_if #(
  parameter int unsigned CNT_W = 32
);
  logic             mem_read;
  logic             mem_write;
  logic             mem_resp;
  logic             pmem_read;
  logic             pmem_write;
  logic             pmem_resp;
  logic             hit;
  logic [1:0]       way_hit;
  logic [1:0]       valid_out;
  logic [1:0]       dirty_out;
  logic             plru;
  logic [1:0]       way_load;
  logic [1:0]       valid_load;
  logic [1:0]       valid_in;
  logic [1:0]       dirty_load;
  logic [1:0]       dirty_in;
  logic             lru_load;
  logic             mru;
  logic             way_sel;
  logic [1:0]       pmem_address_sel;
  logic [1:0]       way_data_in_sel;
  logic [1:0][1:0]  way_write_en_sel;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;
  logic [CNT_W-1:0] wb_count;

  modport master (
    input  mem_read, mem_write, pmem_resp, hit, way_hit, valid_out, dirty_out, plru,
    output mem_resp, pmem_read, pmem_write, way_load, valid_load, valid_in, dirty_load,
           dirty_in, lru_load, mru, way_sel, pmem_address_sel, way_data_in_sel,
           way_write_en_sel, hit_count, miss_count, wb_count
  );

  modport slave (
    output mem_read, mem_write, pmem_resp, hit, way_hit, valid_out, dirty_out, plru,
    input  mem_resp, pmem_read, pmem_write, way_load, valid_load, valid_in, dirty_load,
           dirty_in, lru_load, mru, way_sel, pmem_address_sel, way_data_in_sel,
           way_write_en_sel, hit_count, miss_count, wb_count
  );
endinterface

// File: rtl/l2_cache_control.sv
// Control FSM for the 2-way, 8-set L2 cache datapath: hit resolution, victim choice,
// dirty writeback, refill from physical memory and saturating performance counters.
module l2_cache_control #(
  parameter int unsigned CNT_W = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  l2_cache_control_if.master io_bus
);

  typedef enum logic [1:0] {StIdle, StCheck, StWb, StFill} state_t;
  typedef enum logic {OutWay0, OutWay1} cache_out_mux_sel_t;
  typedef enum logic [1:0] {AddrCpu, AddrDirty0Write, AddrDirty1Write} pmem_addr_mux_sel_t;
  typedef enum logic {DinCachelineAdaptor, DinBusAdaptor} data_in_mux_sel_t;
  typedef enum logic [1:0] {WeIdle, WeCpuWrite, WeLoadMem} data_write_en_mux_sel_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_victim;
  logic                   w_victim_nxt;
  logic                   r_refill;
  logic                   w_refill_nxt;
  logic [CNT_W-1:0]       r_hit_cnt;
  logic [CNT_W-1:0]       r_miss_cnt;
  logic [CNT_W-1:0]       r_wb_cnt;
  logic                   w_hit_inc;
  logic                   w_miss_inc;
  logic                   w_wb_inc;

  logic                   w_req;
  logic                   w_hit_way;
  logic                   w_victim_sel;
  logic                   w_mem_resp;
  logic                   w_pmem_read;
  logic                   w_pmem_write;
  logic [1:0]             w_way_load;
  logic [1:0]             w_valid_load;
  logic [1:0]             w_valid_in;
  logic [1:0]             w_dirty_load;
  logic [1:0]             w_dirty_in;
  logic                   w_lru_load;
  logic                   w_mru;
  cache_out_mux_sel_t     w_way_sel;
  pmem_addr_mux_sel_t     w_addr_sel;
  data_in_mux_sel_t       w_din_sel [2];
  data_write_en_mux_sel_t w_we_sel  [2];

  assign w_req     = io_bus.mem_read | io_bus.mem_write;
  assign w_hit_way = io_bus.way_hit[1];

  // Invalid ways are filled before PLRU is consulted.
  assign w_victim_sel = !io_bus.valid_out[0] ? 1'b0 :
                        !io_bus.valid_out[1] ? 1'b1 : io_bus.plru;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state  <= StIdle;
      r_victim <= 1'b0;
      r_refill <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_victim <= w_victim_nxt;
      r_refill <= w_refill_nxt;
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    return (en && (c != '1)) ? c + CNT_W'(1) : c;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_wb_cnt   <= '0;
    end else begin
      r_hit_cnt  <= sat_inc(r_hit_cnt, w_hit_inc);
      r_miss_cnt <= sat_inc(r_miss_cnt, w_miss_inc);
      r_wb_cnt   <= sat_inc(r_wb_cnt, w_wb_inc);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_victim_nxt = r_victim;
    w_refill_nxt = r_refill;
    w_hit_inc    = 1'b0;
    w_miss_inc   = 1'b0;
    w_wb_inc     = 1'b0;
    w_mem_resp   = 1'b0;
    w_pmem_read  = 1'b0;
    w_pmem_write = 1'b0;
    w_way_load   = 2'b00;
    w_valid_load = 2'b00;
    w_valid_in   = 2'b00;
    w_dirty_load = 2'b00;
    w_dirty_in   = 2'b00;
    w_lru_load   = 1'b0;
    w_mru        = 1'b0;
    w_way_sel    = OutWay0;
    w_addr_sel   = AddrCpu;
    w_din_sel[0] = DinCachelineAdaptor;
    w_din_sel[1] = DinCachelineAdaptor;
    w_we_sel[0]  = WeIdle;
    w_we_sel[1]  = WeIdle;

    unique case (r_state)
      StIdle: begin
        if (w_req) w_state_nxt = StCheck;
      end

      StCheck: begin
        if (!w_req) begin
          w_state_nxt  = StIdle;
          w_refill_nxt = 1'b0;
        end else if (io_bus.hit) begin
          w_mem_resp = 1'b1;
          w_way_sel  = cache_out_mux_sel_t'(w_hit_way);
          w_lru_load = 1'b1;
          w_mru      = w_hit_way;
          // A simultaneous read and write is serviced as a write.
          if (io_bus.mem_write) begin
            w_we_sel[w_hit_way]     = WeCpuWrite;
            w_din_sel[w_hit_way]    = DinBusAdaptor;
            w_dirty_load[w_hit_way] = 1'b1;
            w_dirty_in[w_hit_way]   = 1'b1;
          end
          // The hit that completes a refill was already counted as a miss.
          w_hit_inc    = !r_refill;
          w_refill_nxt = 1'b0;
          w_state_nxt  = StIdle;
        end else begin
          w_victim_nxt = w_victim_sel;
          w_miss_inc   = 1'b1;
          w_state_nxt  = (io_bus.valid_out[w_victim_sel] && io_bus.dirty_out[w_victim_sel]) ?
                         StWb : StFill;
        end
      end

      StWb: begin
        w_pmem_write = 1'b1;
        w_addr_sel   = r_victim ? AddrDirty1Write : AddrDirty0Write;
        w_way_sel    = cache_out_mux_sel_t'(r_victim);
        if (io_bus.pmem_resp) begin
          w_wb_inc    = 1'b1;
          w_state_nxt = StFill;
        end
      end

      StFill: begin
        w_pmem_read = 1'b1;
        if (io_bus.pmem_resp) begin
          w_we_sel[r_victim]     = WeLoadMem;
          w_way_load[r_victim]   = 1'b1;
          w_valid_load[r_victim] = 1'b1;
          w_valid_in[r_victim]   = 1'b1;
          w_dirty_load[r_victim] = 1'b1;
          w_refill_nxt           = 1'b1;
          w_state_nxt            = StCheck;
        end
      end

      default: w_state_nxt = StIdle;
    endcase
  end

  assign io_bus.mem_resp            = w_mem_resp;
  assign io_bus.pmem_read           = w_pmem_read;
  assign io_bus.pmem_write          = w_pmem_write;
  assign io_bus.way_load            = w_way_load;
  assign io_bus.valid_load          = w_valid_load;
  assign io_bus.valid_in            = w_valid_in;
  assign io_bus.dirty_load          = w_dirty_load;
  assign io_bus.dirty_in            = w_dirty_in;
  assign io_bus.lru_load            = w_lru_load;
  assign io_bus.mru                 = w_mru;
  assign io_bus.way_sel             = w_way_sel;
  assign io_bus.pmem_address_sel    = w_addr_sel;
  assign io_bus.way_data_in_sel[0]  = w_din_sel[0];
  assign io_bus.way_data_in_sel[1]  = w_din_sel[1];
  assign io_bus.way_write_en_sel[0] = w_we_sel[0];
  assign io_bus.way_write_en_sel[1] = w_we_sel[1];
  assign io_bus.hit_count           = r_hit_cnt;
  assign io_bus.miss_count          = r_miss_cnt;
  assign io_bus.wb_count            = r_wb_cnt;

endmodule

// File: tb/tb_l2_cache_control.sv
// Bench for l2_cache_control: directed and random transactions checked cycle by cycle against a
// transaction-level model of the controller's documented behaviour.
module tb_l2_cache_control;
  localparam int unsigned CW = 4;
  localparam int          SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  l2_cache_control_if #(.CNT_W(CW)) bus ();

  l2_cache_control #(.CNT_W(CW)) dut (
    .i_clk  (clk),
    .i_rst  (rst_n),
    .io_bus (bus)
  );

  typedef struct packed {
    logic       mem_resp;
    logic       pmem_read;
    logic       pmem_write;
    logic       lru_load;
    logic       mru;
    logic       way_sel;
    logic [1:0] addr;
    logic [1:0] way_load;
    logic [1:0] valid_load;
    logic [1:0] valid_in;
    logic [1:0] dirty_load;
    logic [1:0] dirty_in;
    logic [1:0] din;
    logic [3:0] we;
  } ctl_t;

  int n_vec = 0;
  int n_err = 0;
  int m_hit = 0;
  int m_miss = 0;
  int m_wb = 0;
  bit m_refill = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ctl_t sample_ctl();
    ctl_t c;
    c.mem_resp   = bus.mem_resp;
    c.pmem_read  = bus.pmem_read;
    c.pmem_write = bus.pmem_write;
    c.lru_load   = bus.lru_load;
    c.mru        = bus.mru;
    c.way_sel    = bus.way_sel;
    c.addr       = bus.pmem_address_sel;
    c.way_load   = bus.way_load;
    c.valid_load = bus.valid_load;
    c.valid_in   = bus.valid_in;
    c.dirty_load = bus.dirty_load;
    c.dirty_in   = bus.dirty_in;
    c.din        = bus.way_data_in_sel;
    c.we         = bus.way_write_en_sel;
    return c;
  endfunction

  task automatic check_ctl(input string tag, input ctl_t e);
    chk(tag, 64'(sample_ctl()), 64'(e));
  endtask

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  task automatic check_counters(input string tag);
    chk({tag, ".hit_count"}, 64'(bus.hit_count), 64'(sat(m_hit)));
    chk({tag, ".miss_count"}, 64'(bus.miss_count), 64'(sat(m_miss)));
    chk({tag, ".wb_count"}, 64'(bus.wb_count), 64'(sat(m_wb)));
  endtask

  // Encodings: way_0=0, cpu=0, dirty_0_write=1, dirty_1_write=2, bus_adaptor=1,
  // cpu_write=1, load_mem=2; every default is encoding 0.
  function automatic ctl_t hit_ctl(input bit w, input int idx);
    ctl_t e = '0;
    e.mem_resp = 1'b1;
    e.way_sel  = idx[0];
    e.lru_load = 1'b1;
    e.mru      = idx[0];
    if (w) begin
      e.we[idx*2 +: 2] = 2'd1;
      e.din[idx]        = 1'b1;
      e.dirty_load[idx] = 1'b1;
      e.dirty_in[idx]   = 1'b1;
    end
    return e;
  endfunction

  // One upstream request from IDLE back to IDLE; entered and left at a falling edge.
  task automatic txn(input string tag, input bit rd, input bit wr, input bit is_hit,
                     input logic [1:0] whit, input logic [1:0] vld, input logic [1:0] dty,
                     input bit pl, input int wb_lat, input int fl_lat, input bit drop);
    ctl_t e;
    int   vic;
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.hit       = 1'b0;
    bus.pmem_resp = 1'b0;
    #1 check_ctl({tag, ".idle"}, '0);
    @(negedge clk);
    bus.hit       = is_hit;
    bus.way_hit   = whit;
    bus.valid_out = vld;
    bus.dirty_out = dty;
    bus.plru      = pl;
    #1;
    if (is_hit) begin
      check_ctl({tag, ".hit"}, hit_ctl(wr, int'(whit[1])));
      if (!m_refill) m_hit++;
      m_refill = 1'b0;
    end else begin
      check_ctl({tag, ".miss"}, '0);
      vic = !vld[0] ? 0 : !vld[1] ? 1 : int'(pl);
      m_miss++;
      if (vld[vic] && dty[vic]) begin
        for (int i = 0; i < wb_lat; i++) begin
          @(negedge clk);
          bus.pmem_resp = (i == wb_lat - 1);
          bus.plru      = 1'($urandom);
          bus.valid_out = 2'($urandom);
          bus.hit       = 1'($urandom);
          #1;
          e            = '0;
          e.pmem_write = 1'b1;
          e.addr       = (vic == 1) ? 2'd2 : 2'd1;
          e.way_sel    = vic[0];
          check_ctl({tag, ".wb"}, e);
        end
        m_wb++;
      end
      for (int i = 0; i < fl_lat; i++) begin
        @(negedge clk);
        bus.pmem_resp = (i == fl_lat - 1);
        bus.plru      = 1'($urandom);
        bus.valid_out = 2'($urandom);
        #1;
        e           = '0;
        e.pmem_read = 1'b1;
        if (i == fl_lat - 1) begin
          e.we[vic*2 +: 2]  = 2'd2;
          e.way_load[vic]   = 1'b1;
          e.valid_load[vic] = 1'b1;
          e.valid_in[vic]   = 1'b1;
          e.dirty_load[vic] = 1'b1;
        end
        check_ctl({tag, ".fill"}, e);
      end
      m_refill = 1'b1;
      @(negedge clk);
      bus.pmem_resp = 1'b0;
      if (drop) begin
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        #1 check_ctl({tag, ".drop"}, '0);
        m_refill = 1'b0;
      end else begin
        bus.hit     = 1'b1;
        bus.way_hit = (vic == 1) ? 2'b10 : 2'b01;
        #1 check_ctl({tag, ".refill_hit"}, hit_ctl(wr, vic));
        m_refill = 1'b0;
      end
    end
    @(negedge clk);
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.hit       = 1'b0;
    bus.pmem_resp = 1'b0;
    #1 check_counters(tag);
  endtask

  bit         r_rd;
  bit         r_wr;
  bit         r_hit;
  bit         r_b;
  int         r_kind;

  initial begin
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.pmem_resp = 1'b0;
    bus.hit       = 1'b0;
    bus.way_hit   = 2'b00;
    bus.valid_out = 2'b00;
    bus.dirty_out = 2'b00;
    bus.plru      = 1'b0;

    #1 check_ctl("reset.ctl", '0);
    check_counters("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Cold read, fill answered on its third cycle, then the refill hit is not counted.
    txn("cold_read", 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 3, 0);
    txn("read_hit_w1", 1, 0, 1, 2'b10, 2'b11, 2'b00, 0, 0, 0, 0);
    txn("write_hit_w0", 0, 1, 1, 2'b01, 2'b11, 2'b00, 1, 0, 0, 0);
    txn("dirty_miss_w1", 1, 0, 0, 2'b00, 2'b11, 2'b10, 1, 3, 2, 0);
    txn("rw_hit_w1", 1, 1, 1, 2'b10, 2'b11, 2'b00, 0, 0, 0, 0);
    txn("second_invalid", 0, 1, 0, 2'b00, 2'b01, 2'b11, 0, 0, 1, 0);
    txn("clean_plru0", 1, 0, 0, 2'b00, 2'b11, 2'b10, 0, 0, 2, 0);
    // Request dropped in the CHECK after refill: no response and refill is cleared.
    txn("drop_after_fill", 1, 0, 0, 2'b00, 2'b11, 2'b00, 1, 0, 2, 1);
    txn("hit_after_drop", 1, 0, 1, 2'b01, 2'b11, 2'b00, 0, 0, 0, 0);

    for (int t = 0; t < 40; t++) begin
      r_kind = int'($urandom_range(0, 2));
      r_rd   = (r_kind != 1);
      r_wr   = (r_kind != 0);
      r_hit  = 1'($urandom);
      r_b    = 1'($urandom);
      txn("random", r_rd, r_wr, r_hit, {r_b, ~r_b}, 2'($urandom), 2'($urandom),
          1'($urandom), int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), 0);
    end

    for (int t = 0; t < 20; t++) begin
      txn("sat_hit", 1, 0, 1, 2'b01, 2'b11, 2'b00, 0, 0, 0, 0);
    end
    chk("hit_saturated", 64'(bus.hit_count), 64'(SAT));

    // Reset asserted in the middle of a fill.
    bus.mem_read = 1'b1;
    #1 check_ctl("rst_fill.idle", '0);
    @(negedge clk);
    bus.hit       = 1'b0;
    bus.valid_out = 2'b00;
    bus.dirty_out = 2'b00;
    @(negedge clk);
    #1 chk("rst_fill.pmem_read_before", 64'(bus.pmem_read), 64'(1));
    #2 rst_n = 1'b0;
    #1 chk("rst_fill.pmem_read_after", 64'(bus.pmem_read), 64'(0));
    check_ctl("rst_fill.ctl", '0);
    m_hit    = 0;
    m_miss   = 0;
    m_wb     = 0;
    m_refill = 1'b0;
    check_counters("rst_fill");
    bus.mem_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    txn("after_reset", 1, 0, 1, 2'b10, 2'b11, 2'b00, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
